// File: rtl/round_robin_arbiter_4.sv
// Four-requester round-robin arbiter with rotating priority pointer, a hold-time
// limit that forces rotation when others wait, and registered grant outputs.
module round_robin_arbiter_4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       rel,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic [3:0] others;
    logic       quit;
    logic       forced;
    logic [1:0] next_ptr;
    logic [1:0] idle_pick;
    logic [1:0] hand_pick;

    // First set bit of v scanning start, start+1, ... (mod 4); lowest offset wins.
    function automatic logic [1:0] pick(input logic [3:0] v, input logic [1:0] start);
        logic [1:0] idx;
        pick = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (v[idx]) pick = idx;
        end
    endfunction

    always_comb begin
        others    = req & ~(4'b0001 << gnt_id);
        quit      = rel | ~req[gnt_id];
        forced    = (hold_cnt == HOLD_MAX) && (others != 4'b0000);
        next_ptr  = gnt_id + 2'd1;
        idle_pick = pick(req, ptr);
        hand_pick = pick(others, next_ptr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= 2'd0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (req != 4'b0000) begin
                        state     <= GRANT;
                        gnt       <= 4'b0001 << idle_pick;
                        gnt_id    <= idle_pick;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= CNT_W'(1);
                    end
                end
                GRANT: begin
                    if (quit || forced) begin
                        ptr <= next_ptr;
                        // A coincident release/withdrawal takes precedence over the limit.
                        timeout <= ~quit;
                        if (others != 4'b0000) begin
                            gnt      <= 4'b0001 << hand_pick;
                            gnt_id   <= hand_pick;
                            hold_cnt <= CNT_W'(1);
                        end else begin
                            state     <= IDLE;
                            gnt       <= 4'b0000;
                            gnt_id    <= 2'd0;
                            gnt_valid <= 1'b0;
                            hold_cnt  <= '0;
                        end
                    end else begin
                        timeout <= 1'b0;
                        if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_round_robin_arbiter_4.sv
// Bench for round_robin_arbiter_4: directed literal checks from the test plan plus
// randomized traffic compared each cycle against a tenure-level reference model.
module tb_round_robin_arbiter_4;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       rel = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    round_robin_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .rel(rel),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the resource, how long, and where priority starts.
    int owner   = -1;
    int held    = 0;
    int start   = 0;
    bit exp_to  = 0;
    bit started = 0;

    function automatic int first_from(input bit [3:0] v, input int s);
        for (int k = 0; k < 4; k++)
            if (v[(s + k) % 4]) return (s + k) % 4;
        return -1;
    endfunction

    always @(posedge clk) begin
        bit [3:0] rest;
        bit       leave;
        bit       limit;
        started <= 1'b1;
        if (rst) begin
            owner = -1; held = 0; start = 0; exp_to = 0;
        end else if (owner < 0) begin
            exp_to = 0;
            owner  = first_from(req, start);
            held   = (owner >= 0) ? 1 : 0;
        end else begin
            rest  = req;
            rest[owner] = 1'b0;
            leave = rel || !req[owner];
            limit = (held == MAX_HOLD) && (rest != 0);
            if (leave || limit) begin
                start  = (owner + 1) % 4;
                exp_to = !leave;
                owner  = first_from(rest, start);
                held   = (owner >= 0) ? 1 : 0;
            end else begin
                exp_to = 0;
                if (held < MAX_HOLD) held++;
            end
        end
    end

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("model_gnt",       int'(gnt),       (owner < 0) ? 0 : (1 << owner));
            chk("model_gnt_id",    int'(gnt_id),    (owner < 0) ? 0 : owner);
            chk("model_gnt_valid", int'(gnt_valid), (owner < 0) ? 0 : 1);
            chk("model_timeout",   int'(timeout),   int'(exp_to));
        end
    end

    task automatic cyc(input bit r, input bit [3:0] q, input bit l);
        rst = r; req = q; rel = l;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lit(input string name, input bit [3:0] g, input bit v, input bit t);
        chk({name, "_gnt"}, int'(gnt), int'(g));
        chk({name, "_valid"}, int'(gnt_valid), int'(v));
        chk({name, "_timeout"}, int'(timeout), int'(t));
    endtask

    task automatic do_reset();
        cyc(1, 4'b0000, 0);
        lit("reset", 4'b0000, 0, 0);
    endtask

    initial begin
        // 1: reset with all requesting, then first grant to requester 0
        cyc(1, 4'b1111, 0);
        cyc(1, 4'b1111, 0);
        lit("t1_reset", 4'b0000, 0, 0);
        chk("t1_reset_id", int'(gnt_id), 0);
        cyc(0, 4'b1111, 0);
        lit("t1_first", 4'b0001, 1, 0);

        // 2: releases rotate 1,2,3,0 with no bubble
        cyc(0, 4'b1111, 1); lit("t2_g1", 4'b0010, 1, 0);
        cyc(0, 4'b1111, 1); lit("t2_g2", 4'b0100, 1, 0);
        cyc(0, 4'b1111, 1); lit("t2_g3", 4'b1000, 1, 0);
        cyc(0, 4'b1111, 1); lit("t2_g0", 4'b0001, 1, 0);

        // 3: hold limit forces rotation between 0 and 2
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(0, 4'b0101, 0); lit("t3_hold0", 4'b0001, 1, 0);
        end
        cyc(0, 4'b0101, 0); lit("t3_to2", 4'b0100, 1, 1);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 4'b0101, 0); lit("t3_hold2", 4'b0100, 1, 0);
        end
        cyc(0, 4'b0101, 0); lit("t3_to0", 4'b0001, 1, 1);

        // 4: lone requester holds indefinitely; self-release costs one idle cycle
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(0, 4'b0010, 0); lit("t4_lone", 4'b0010, 1, 0);
        end
        chk("t4_id", int'(gnt_id), 1);
        cyc(0, 4'b0010, 1); lit("t4_idle", 4'b0000, 0, 0);
        cyc(0, 4'b0010, 0); lit("t4_regrant", 4'b0010, 1, 0);

        // 5: withdrawal hand-offs
        do_reset();
        cyc(0, 4'b0100, 0); lit("t5_own2", 4'b0100, 1, 0);
        cyc(0, 4'b1101, 0); lit("t5_keep2", 4'b0100, 1, 0);
        cyc(0, 4'b1001, 0); lit("t5_to3", 4'b1000, 1, 0);
        chk("t5_id3", int'(gnt_id), 3);
        cyc(0, 4'b0001, 0); lit("t5_to0", 4'b0001, 1, 0);
        cyc(0, 4'b0000, 0); lit("t5_none", 4'b0000, 0, 0);

        // 6: reset mid-tenure clears pointer
        do_reset();
        cyc(0, 4'b0100, 0);
        cyc(0, 4'b0100, 0);
        cyc(0, 4'b0100, 0); lit("t6_own2", 4'b0100, 1, 0);
        cyc(1, 4'b1111, 0); lit("t6_rst", 4'b0000, 0, 0);
        cyc(0, 4'b1111, 0); lit("t6_ptr0", 4'b0001, 1, 0);

        // Randomized traffic: sticky requests so hold limits are reached
        begin
            bit [3:0] q = 4'b1111;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 9) == 0) q = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 19) == 0) q[$urandom_range(0, 3)] ^= 1'b1;
                cyc(($urandom_range(0, 199) == 0), q, ($urandom_range(0, 6) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
